// File: rtl/conv_window_ctrl.sv
// Sequencing controller for a 3x3 convolution window fed by a two-line buffer chain.
// Latency: a window becomes valid on the edge after its bottom-right pixel is accepted.
// Backpressure: a held window with out_ready low stops pixel acceptance (in_ready low).
module conv_window_ctrl #(
    parameter int IMG_WIDTH  = 6,
    parameter int IMG_HEIGHT = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       lb_wr_en,
    input  logic       out_ready,
    output logic       win_valid,
    output logic [9:0] win_col,
    output logic [9:0] win_row,
    output logic       busy,
    output logic       frame_done
);

    // Image dimensions must fit the 10-bit counters and leave room for a 3x3 window.
    if ((IMG_WIDTH < 3) || (IMG_WIDTH > 1024) || (IMG_HEIGHT < 3) || (IMG_HEIGHT > 1024)) begin : g_bad_params
        $error("conv_window_ctrl: IMG_WIDTH/IMG_HEIGHT must be within 3..1024");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } state_t;

    localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_HEIGHT - 1);

    state_t     state;
    logic [9:0] col;
    logic [9:0] row;
    logic       accept;
    logic       col_wrap;
    logic       win_load;
    logic       win_take;

    // Pixels flow only while filling/running and no window is stuck waiting downstream.
    assign in_ready = ((state == ST_FILL) || (state == ST_RUN)) && (!win_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign lb_wr_en = accept;
    assign busy     = (state != ST_IDLE);
    assign col_wrap = (col == COL_LAST);
    // Windows exist only once two full rows are buffered and the column reaches 2.
    assign win_load = accept && (state == ST_RUN) && (col >= 10'd2);
    assign win_take = win_valid && out_ready;

    // Frame FSM, pixel position counters and the frame completion pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FILL;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                ST_FILL: begin
                    if (accept && col_wrap && (row == 10'd1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && col_wrap && (row == ROW_LAST)) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Leave once the final window has been taken (or if none is pending).
                    if (!win_valid || out_ready) begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                if (col_wrap) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? 10'd0 : row + 10'd1;
                end else begin
                    col <= col + 10'd1;
                end
            end
        end
    end

    // Output window register: a new window load wins over the downstream take.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
        end else if (win_load) begin
            win_valid <= 1'b1;
            win_col   <= col;
            win_row   <= row;
        end else if (win_take) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: 6x6 instance for the main scenarios, 3x3 instance for the minimum size.
// Inputs change on the falling edge; outputs are sampled 1-2 time units later.
// A bench-side model predicts the raster order of windows handed downstream.
module tb_conv_window_ctrl;

    localparam int W = 6;
    localparam int H = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, in_valid, out_ready;
    logic       in_ready, lb_wr_en, win_valid, busy, frame_done;
    logic [9:0] win_col, win_row;

    logic       s_start, s_in_valid, s_out_ready;
    logic       s_in_ready, s_lb_wr_en, s_win_valid, s_busy, s_frame_done;
    logic [9:0] s_win_col, s_win_row;

    int checks = 0;
    int errors = 0;

    // Monitor statistics and window-order model state
    int         acc_cnt, win_cnt, fd_cnt, lb_bad, seq_err, first_win_acc;
    int         exp_c, exp_r;
    logic [9:0] last_c, last_r;

    always #5 clock = ~clock;

    conv_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .lb_wr_en(lb_wr_en), .out_ready(out_ready), .win_valid(win_valid), .win_col(win_col),
        .win_row(win_row), .busy(busy), .frame_done(frame_done)
    );

    conv_window_ctrl #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .clock(clock), .reset(reset), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .lb_wr_en(s_lb_wr_en), .out_ready(s_out_ready), .win_valid(s_win_valid), .win_col(s_win_col),
        .win_row(s_win_row), .busy(s_busy), .frame_done(s_frame_done)
    );

    task automatic clear_stats();
        acc_cnt = 0; win_cnt = 0; fd_cnt = 0; lb_bad = 0; seq_err = 0;
        first_win_acc = -1; exp_c = 2; exp_r = 2; last_c = '0; last_r = '0;
    endtask

    // One clock cycle: called just after a falling edge with inputs already set.
    task automatic step();
        #1;
        if (win_valid === 1'b1 && first_win_acc < 0) first_win_acc = acc_cnt;
        if (lb_wr_en !== (in_valid && in_ready)) lb_bad++;
        if (win_valid === 1'b1 && out_ready) begin
            win_cnt++;
            if (win_col !== 10'(exp_c) || win_row !== 10'(exp_r)) seq_err++;
            last_c = win_col; last_r = win_row;
            exp_c++;
            if (exp_c == W) begin exp_c = 2; exp_r++; end
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (in_valid && in_ready) acc_cnt++;
        @(negedge clock);
    endtask

    task automatic do_start();
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
    endtask

    // stop_kind: 0 = frame_done seen, 1 = window (3,2) presented, 2 = stop_n accepts.
    task automatic run(input int mode, input int stop_kind, input int stop_n, input int limit, output bit timeout);
        int  n;
        bit  done;
        n = 0; done = 0; timeout = 0;
        while (!done) begin
            if (stop_kind == 0 && fd_cnt > 0) done = 1;
            else if (stop_kind == 1 && win_valid === 1'b1 && win_col == 10'd3 && win_row == 10'd2) done = 1;
            else if (stop_kind == 2 && acc_cnt >= stop_n) done = 1;
            else if (n >= limit) begin timeout = 1; done = 1; end
            else begin
                in_valid  = (mode == 1) ? (n % 2 == 0) : 1'b1;
                out_ready = 1'b1;
                step();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        s_start = 1'b1; s_in_valid = 1'b1; s_out_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (lb_wr_en !== 1'b0)   begin errors++; $display("FAIL reset_lb_wr_en got %b exp 0", lb_wr_en); end
        checks++; if (win_valid !== 1'b0)  begin errors++; $display("FAIL reset_win_valid got %b exp 0", win_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        checks++; if (win_col !== 10'd0 || win_row !== 10'd0)
            begin errors++; $display("FAIL reset_coords got (%0d,%0d) exp (0,0)", win_col, win_row); end
        @(negedge clock);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        s_start = 1'b0; s_in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_continuous();
        bit to;
        clear_stats();
        do_start();
        run(0, 0, 0, 200, to);
        checks++; if (to !== 1'b0)        begin errors++; $display("FAIL cont_timeout got %b exp 0", to); end
        checks++; if (acc_cnt !== 36)     begin errors++; $display("FAIL cont_accepts got %0d exp 36", acc_cnt); end
        checks++; if (win_cnt !== 16)     begin errors++; $display("FAIL cont_windows got %0d exp 16", win_cnt); end
        checks++; if (first_win_acc !== 15) begin errors++; $display("FAIL cont_first_win got %0d exp 15", first_win_acc); end
        checks++; if (seq_err !== 0)      begin errors++; $display("FAIL cont_sequence got %0d exp 0", seq_err); end
        checks++; if (last_c !== 10'd5 || last_r !== 10'd5)
            begin errors++; $display("FAIL cont_last_win got (%0d,%0d) exp (5,5)", last_c, last_r); end
        checks++; if (lb_bad !== 0)       begin errors++; $display("FAIL cont_lb_wr_en got %0d exp 0", lb_bad); end
        in_valid = 1'b0;
        step();
        checks++; if (fd_cnt !== 1)       begin errors++; $display("FAIL cont_frame_done got %0d exp 1", fd_cnt); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL cont_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_stall();
        bit to;
        clear_stats();
        do_start();
        run(0, 1, 0, 200, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_reach_timeout got %b exp 0", to); end
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0; in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b exp 0", i, in_ready); end
            checks++; if (lb_wr_en !== 1'b0) begin errors++; $display("FAIL stall_lb_wr_en cyc %0d got %b exp 0", i, lb_wr_en); end
            checks++; if (win_valid !== 1'b1 || win_col !== 10'd3 || win_row !== 10'd2)
                begin errors++; $display("FAIL stall_hold cyc %0d got v%b (%0d,%0d) exp v1 (3,2)", i, win_valid, win_col, win_row); end
            step();
        end
        run(0, 0, 0, 200, to);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL stall_timeout got %b exp 0", to); end
        checks++; if (win_cnt !== 16) begin errors++; $display("FAIL stall_windows got %0d exp 16", win_cnt); end
        checks++; if (seq_err !== 0)  begin errors++; $display("FAIL stall_sequence got %0d exp 0", seq_err); end
        checks++; if (acc_cnt !== 36) begin errors++; $display("FAIL stall_accepts got %0d exp 36", acc_cnt); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_toggle();
        bit to;
        clear_stats();
        do_start();
        run(1, 0, 0, 300, to);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL toggle_timeout got %b exp 0", to); end
        checks++; if (acc_cnt !== 36) begin errors++; $display("FAIL toggle_accepts got %0d exp 36", acc_cnt); end
        checks++; if (win_cnt !== 16) begin errors++; $display("FAIL toggle_windows got %0d exp 16", win_cnt); end
        checks++; if (seq_err !== 0)  begin errors++; $display("FAIL toggle_sequence got %0d exp 0", seq_err); end
        checks++; if (lb_bad !== 0)   begin errors++; $display("FAIL toggle_lb_wr_en got %0d exp 0", lb_bad); end
        checks++; if (fd_cnt !== 1)   begin errors++; $display("FAIL toggle_frame_done got %0d exp 1", fd_cnt); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_midframe();
        bit to;
        clear_stats();
        do_start();
        run(0, 2, 20, 200, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL midrst_reach_timeout got %b exp 0", to); end
        // Assert reset between edges; outputs must drop without waiting for a clock.
        #2 reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || lb_wr_en !== 1'b0)
            begin errors++; $display("FAIL midrst_ready got rdy%b wr%b exp 0 0", in_ready, lb_wr_en); end
        checks++; if (busy !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0)
            begin errors++; $display("FAIL midrst_flags got busy%b wv%b fd%b exp 0 0 0", busy, win_valid, frame_done); end
        checks++; if (win_col !== 10'd0 || win_row !== 10'd0)
            begin errors++; $display("FAIL midrst_coords got (%0d,%0d) exp (0,0)", win_col, win_row); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        clear_stats();
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (5) step();
        checks++; if (acc_cnt !== 0 || busy !== 1'b0)
            begin errors++; $display("FAIL midrst_idle got acc%0d busy%b exp 0 0", acc_cnt, busy); end
        checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", fd_cnt); end
        clear_stats();
        do_start();
        run(0, 0, 0, 200, to);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL midrst_timeout got %b exp 0", to); end
        checks++; if (win_cnt !== 16 || seq_err !== 0)
            begin errors++; $display("FAIL midrst_frame got %0d windows %0d seqerr exp 16 0", win_cnt, seq_err); end
        checks++; if (fd_cnt !== 1)   begin errors++; $display("FAIL midrst_frame_done got %0d exp 1", fd_cnt); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_start_in_run();
        bit to;
        clear_stats();
        do_start();
        run(0, 2, 20, 200, to);
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        run(0, 0, 0, 200, to);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL startrun_timeout got %b exp 0", to); end
        checks++; if (acc_cnt !== 36) begin errors++; $display("FAIL startrun_accepts got %0d exp 36", acc_cnt); end
        checks++; if (win_cnt !== 16 || seq_err !== 0)
            begin errors++; $display("FAIL startrun_frame got %0d windows %0d seqerr exp 16 0", win_cnt, seq_err); end
        checks++; if (fd_cnt !== 1)   begin errors++; $display("FAIL startrun_frame_done got %0d exp 1", fd_cnt); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_small();
        int         acc, wins, fds, first;
        logic [9:0] wc, wr;
        acc = 0; wins = 0; fds = 0; first = -1; wc = '0; wr = '0;
        s_start = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b1;
        @(negedge clock);
        s_start = 1'b0; s_in_valid = 1'b1;
        for (int n = 0; n < 40 && fds == 0; n++) begin
            #1;
            if (s_win_valid === 1'b1 && first < 0) first = acc;
            if (s_win_valid === 1'b1 && s_out_ready) begin wins++; wc = s_win_col; wr = s_win_row; end
            if (s_frame_done === 1'b1) fds++;
            if (s_in_valid && s_in_ready) acc++;
            @(negedge clock);
        end
        s_in_valid = 1'b0;
        #1;
        checks++; if (acc !== 9)   begin errors++; $display("FAIL small_accepts got %0d exp 9", acc); end
        checks++; if (wins !== 1)  begin errors++; $display("FAIL small_windows got %0d exp 1", wins); end
        checks++; if (wc !== 10'd2 || wr !== 10'd2)
            begin errors++; $display("FAIL small_coords got (%0d,%0d) exp (2,2)", wc, wr); end
        checks++; if (first !== 9) begin errors++; $display("FAIL small_first_win got %0d exp 9", first); end
        checks++; if (fds !== 1)   begin errors++; $display("FAIL small_frame_done got %0d exp 1", fds); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL small_busy_after got %b exp 0", s_busy); end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_stall();
        test_toggle();
        test_reset_midframe();
        test_start_in_run();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter IMG_WIDTH, default 6, pixels per row; legal range 3..1024.
REQ-002 Parameter IMG_HEIGHT, default 6, rows per frame; legal range 3..1024.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  frame-start pulse; sampled only in IDLE.
REQ-006 in_valid  input  1  upstream pixel available.
REQ-007 in_ready  output  1  controller accepts a pixel this cycle.
REQ-008 lb_wr_en  output  1  shift/write enable to the two-stage line buffer chain and window registers.
REQ-009 out_ready  input  1  downstream accepts the presented window.
REQ-010 win_valid  output  1  complete 3x3 window is presented.
REQ-011 win_col  output  10  column of the window's bottom-right pixel.
REQ-012 win_row  output  10  row of the window's bottom-right pixel.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 Pixel acceptance ("accept") occurs when in_valid && in_ready, both high on the same rising edge.
REQ-016 lb_wr_en SHALL be combinationally equal to accept.
REQ-017 in_ready = (state is FILL or RUN) && (!win_valid || out_ready).
REQ-018 States: IDLE, FILL, RUN, FLUSH; encoding is free.
REQ-019 IDLE -> FILL when start=1; col and row counters are cleared on this transition.
REQ-020 start is ignored in FILL, RUN and FLUSH.
REQ-021 Counter col advances 0..IMG_WIDTH-1 on each accept, wraps to 0 and then increments row.
REQ-022 FILL -> RUN on accept of pixel (col=IMG_WIDTH-1, row=1).
REQ-023 RUN -> FLUSH on accept of pixel (col=IMG_WIDTH-1, row=IMG_HEIGHT-1); no further accepts occur in FLUSH.
REQ-024 On an accept in RUN with col>=2, win_valid is set on the next edge, and win_col/win_row are loaded with that pixel's col/row.
REQ-025 Accepts with col<2, and all accepts in FILL, do not produce windows.
REQ-026 Once set, win_valid and its coordinates are held stable until a cycle with out_ready=1.
REQ-027 On the edge where win_valid && out_ready, win_valid clears unless a new window is loaded on that same edge (load takes priority).
REQ-028 FLUSH -> IDLE on the edge where win_valid && out_ready; frame_done pulses high for exactly the following cycle.
REQ-029 If win_valid=0 on entry to FLUSH, the controller goes to IDLE on the next edge and pulses frame_done.
REQ-030 Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2); latency from accept to win_valid = 1 cycle.
REQ-031 Counters are 10 bits; no overflow for legal parameters; out-of-range parameters are a synthesis/elaboration error.

Reset
REQ-032 While reset=1: state=IDLE; col, row, win_col, win_row = 0; win_valid, frame_done, busy, in_ready, lb_wr_en = 0.
REQ-033 Assertion mid-frame aborts the frame immediately, with no frame_done pulse.
REQ-034 After reset deassertion, the controller waits for a fresh start.

Verification
REQ-035 Defaults, start, in_valid=1 and out_ready=1 continuously -> 36 accepts, 16 windows; first win_valid the cycle after the 15th accept (col2,row2); last window (5,5); frame_done pulses once; busy low afterwards.
REQ-036 out_ready=0 for 4 cycles while win_valid=1 at (3,2) -> in_ready=0, lb_wr_en=0, win_col=3, win_row=2 held; traffic resumes with no window lost or duplicated.
REQ-037 in_valid toggled 1/0 every cycle -> window count and coordinate sequence match REQ-035; lb_wr_en pulses only on accepts.
REQ-038 Reset asserted after 20 accepts -> all outputs 0 asynchronously; no frame_done; a new start gives a full 16-window frame.
REQ-039 start pulsed during RUN -> ignored; counters and window sequence unaffected.
REQ-040 IMG_WIDTH=3, IMG_HEIGHT=3 -> exactly one window at (2,2) after 9 accepts, then frame_done.
